mem_arb: RTL and testbench

Two-port memory arbiter that shares the single `mem` port between the processor-side path (port A: APR, through PAG/cache) and a DMA requester (port B). It sequences one transaction at a time onto the memory interface, returns each acknowledge to the owning requester, and synthesizes an NXM when memory fails to answer within a bounded time. It sits between the cache/PAG level and `mem`, reusing the `mem` handshake on every side.

---
 rtl/mem_arb.sv | 117 +++++++++++
 tb/tb_mem_arb.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// Two-port arbiter sharing one memory port between port A (processor path) and port B (DMA).
// One transaction at a time; acks are routed combinationally, and a missing ack becomes an NXM.
module mem_arb #(
  parameter int TIMEOUT    = 64,
  parameter int A_PRIORITY = 1,
  parameter int PADDR_W    = 22,
  parameter int WORD_W     = 36
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PADDR_W-1:0] a_addr,
  input  logic [WORD_W-1:0]  a_write_data,
  input  logic               a_read,
  input  logic               a_write,
  output logic [WORD_W-1:0]  a_read_data,
  output logic               a_read_ack,
  output logic               a_write_ack,
  output logic               a_nxm,
  input  logic [PADDR_W-1:0] b_addr,
  input  logic [WORD_W-1:0]  b_write_data,
  input  logic               b_read,
  input  logic               b_write,
  output logic [WORD_W-1:0]  b_read_data,
  output logic               b_read_ack,
  output logic               b_write_ack,
  output logic               b_nxm,
  output logic [PADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0]  mem_write_data,
  output logic               mem_read,
  output logic               mem_write,
  input  logic               mem_read_ack,
  input  logic               mem_write_ack,
  input  logic               mem_nxm,
  input  logic [WORD_W-1:0]  mem_read_data,
  output logic               busy,
  output logic               last_grant
);
  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B, RECOVER} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] cnt_q, cnt_d;

  logic a_req, b_req, gnt_a, gnt_b, gnt;
  logic x_read, x_write, x_req, any_ack, tmo, drive_b;

  assign a_req   = a_read | a_write;
  assign b_req   = b_read | b_write;
  assign gnt_a   = (state_q == GRANT_A);
  assign gnt_b   = (state_q == GRANT_B);
  assign gnt     = gnt_a | gnt_b;
  assign x_read  = gnt_b ? b_read  : a_read;
  assign x_write = gnt_b ? b_write : a_write;
  assign x_req   = x_read | x_write;
  assign any_ack = mem_read_ack | mem_write_ack | mem_nxm;
  // A real ack in the final cycle beats the synthesized NXM.
  assign tmo     = gnt && (cnt_q == CNT_LAST) && !any_ack;

  assign mem_read  = gnt & x_read & ~tmo;
  assign mem_write = gnt & x_write & ~x_read & ~tmo;

  // Port A owns the bus lines whenever nothing is being strobed for B.
  assign drive_b        = gnt_b & (mem_read | mem_write);
  assign mem_addr       = drive_b ? b_addr       : a_addr;
  assign mem_write_data = drive_b ? b_write_data : a_write_data;

  assign a_read_data = mem_read_data;
  assign b_read_data = mem_read_data;
  assign a_read_ack  = gnt_a & mem_read_ack;
  assign a_write_ack = gnt_a & mem_write_ack;
  assign a_nxm       = gnt_a & (mem_nxm | tmo);
  assign b_read_ack  = gnt_b & mem_read_ack;
  assign b_write_ack = gnt_b & mem_write_ack;
  assign b_nxm       = gnt_b & (mem_nxm | tmo);

  assign busy       = gnt;
  assign last_grant = last_grant_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (a_req && (!b_req || (A_PRIORITY != 0) || last_grant_q)) begin
          state_d      = GRANT_A;
          last_grant_d = 1'b0;
          cnt_d        = '0;
        end else if (b_req) begin
          state_d      = GRANT_B;
          last_grant_d = 1'b1;
          cnt_d        = '0;
        end
      end
      GRANT_A, GRANT_B: begin
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        if (any_ack || tmo || !x_req) state_d = RECOVER;
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: per-cycle vector table on two instances (A_PRIORITY 0 and 1),
// plus hand sequences for timeout and reset-during-grant.
module tb_mem_arb;
  localparam logic [21:0] B_ADDR = 22'o200;
  localparam logic [35:0] A_WD   = 36'o1;
  localparam logic [35:0] B_WD   = 36'o2;
  localparam logic [35:0] RD     = 36'o123;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic [21:0] a_addr, b_addr;
  logic [35:0] a_write_data, b_write_data, mem_read_data;
  logic a_read, a_write, b_read, b_write, mem_read_ack, mem_write_ack, mem_nxm;

  logic [1:0][35:0] ard, brd, mwd;
  logic [1:0][21:0] maddr;
  logic [1:0] ara, awa, anx, bra, bwa, bnx, mr, mw, busy, lg;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arb #(.TIMEOUT(8), .A_PRIORITY(g)) u_dut (
      .clk(clk), .reset(reset),
      .a_addr(a_addr), .a_write_data(a_write_data), .a_read(a_read), .a_write(a_write),
      .a_read_data(ard[g]), .a_read_ack(ara[g]), .a_write_ack(awa[g]), .a_nxm(anx[g]),
      .b_addr(b_addr), .b_write_data(b_write_data), .b_read(b_read), .b_write(b_write),
      .b_read_data(brd[g]), .b_read_ack(bra[g]), .b_write_ack(bwa[g]), .b_nxm(bnx[g]),
      .mem_addr(maddr[g]), .mem_write_data(mwd[g]), .mem_read(mr[g]), .mem_write(mw[g]),
      .mem_read_ack(mem_read_ack), .mem_write_ack(mem_write_ack), .mem_nxm(mem_nxm),
      .mem_read_data(mem_read_data), .busy(busy[g]), .last_grant(lg[g])
    );
  end

  // in:  {a_read,a_write,b_read,b_write,mem_read_ack,mem_write_ack,mem_nxm}
  // exp: {mem_read,mem_write,busy,last_grant,a_rack,a_wack,a_nxm,b_rack,b_wack,b_nxm}
  typedef struct {
    bit        p;
    bit        rst;
    bit [6:0]  in;
    bit [9:0]  exp;
    bit        selb;
    bit [21:0] aaddr;
  } vec_t;
  vec_t tbl[$];

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void v(bit p, bit rst, bit [6:0] in, bit [9:0] exp, bit selb, bit [21:0] aa);
    vec_t t;
    t.p = p; t.rst = rst; t.in = in; t.exp = exp; t.selb = selb; t.aaddr = aa;
    tbl.push_back(t);
  endfunction

  task automatic drive(input bit [6:0] in);
    {a_read, a_write, b_read, b_write, mem_read_ack, mem_write_ack, mem_nxm} = in;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(7'b0); reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    a_addr = 22'o1000; b_addr = B_ADDR; a_write_data = A_WD; b_write_data = B_WD;
    mem_read_data = RD;
    drive(7'b0);

    // A reads alone, 1-cycle ack: IDLE, GRANT_A, RECOVER, IDLE
    v(0, 1, 7'b1000000, 10'b0001000000, 0, 22'o1000);
    v(0, 0, 7'b1000100, 10'b1010100000, 0, 22'o1000);
    v(0, 0, 7'b1000000, 10'b0000000000, 0, 22'o1000);
    v(0, 0, 7'b0000000, 10'b0000000000, 0, 22'o1000);
    // both hold writes, round-robin: A,B,A,B
    v(0, 1, 7'b0101000, 10'b0001000000, 0, 22'o100);
    for (int k = 0; k < 2; k++) begin
      v(0, 0, 7'b0101010, 10'b0110010000, 0, 22'o100);
      v(0, 0, 7'b0101000, 10'b0000000000, 0, 22'o100);
      v(0, 0, 7'b0101000, 10'b0000000000, 0, 22'o100);
      v(0, 0, 7'b0101010, 10'b0111000010, 1, 22'o100);
      v(0, 0, 7'b0101000, 10'b0001000000, 0, 22'o100);
      v(0, 0, 7'b0101000, 10'b0001000000, 0, 22'o100);
    end
    // both hold writes, A priority: A three times, B only after A stops
    v(1, 1, 7'b0101000, 10'b0001000000, 0, 22'o100);
    for (int k = 0; k < 3; k++) begin
      v(1, 0, 7'b0101010, 10'b0110010000, 0, 22'o100);
      v(1, 0, (k == 2) ? 7'b0001000 : 7'b0101000, 10'b0000000000, 0, 22'o100);
      v(1, 0, (k == 2) ? 7'b0001000 : 7'b0101000, 10'b0000000000, 0, 22'o100);
    end
    v(1, 0, 7'b0001010, 10'b0111000010, 1, 22'o100);
    v(1, 0, 7'b0000000, 10'b0001000000, 0, 22'o100);
    // A read+write together: read wins
    v(0, 1, 7'b1100000, 10'b0001000000, 0, 22'o1000);
    v(0, 0, 7'b1100100, 10'b1010100000, 0, 22'o1000);
    v(0, 0, 7'b1100000, 10'b0000000000, 0, 22'o1000);
    v(0, 0, 7'b0000000, 10'b0000000000, 0, 22'o1000);

    repeat (2) @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      else @(negedge clk);
      a_addr = tbl[i].aaddr;
      drive(tbl[i].in);
      #1;
      chk($sformatf("vec%0d ctl", i),
          {mr[tbl[i].p], mw[tbl[i].p], busy[tbl[i].p], lg[tbl[i].p], ara[tbl[i].p],
           awa[tbl[i].p], anx[tbl[i].p], bra[tbl[i].p], bwa[tbl[i].p], bnx[tbl[i].p]},
          tbl[i].exp);
      chk($sformatf("vec%0d bus", i), {maddr[tbl[i].p], mwd[tbl[i].p]},
          tbl[i].selb ? {B_ADDR, B_WD} : {tbl[i].aaddr, A_WD});
    end
    chk("read_data", {ard[0], brd[1]}, {RD, RD});

    // B read never acked, TIMEOUT=8: NXM in the 8th grant cycle with strobe dropped
    do_reset();
    b_read = 1'b1;
    begin
      int n;
      n = 0;
      do begin @(negedge clk); #1; n++; end while (!busy[0] && n < 10);
      chk("tmo grant", busy[0], 1'b1);
      for (int i = 0; i < 7; i++) begin
        chk($sformatf("tmo wait%0d", i), {mr[0], bnx[0], anx[0], busy[0]}, 4'b1001);
        @(negedge clk); #1;
      end
      chk("tmo nxm", {mr[0], bnx[0], anx[0], busy[0]}, 4'b0101);
      @(negedge clk);
      b_read = 1'b0;
      #1;
      chk("tmo recover", {mr[0], bnx[0], busy[0]}, 3'b000);
    end

    // reset during GRANT_B, then a late write ack in IDLE
    do_reset();
    b_write = 1'b1;
    @(negedge clk);
    reset = 1'b1; mem_write_ack = 1'b1;
    #1;
    chk("rst grant", {busy[0], mw[0], bwa[0]}, 3'b111);
    @(negedge clk);
    reset = 1'b0; b_write = 1'b0;
    #1;
    chk("rst late ack", {busy[0], mw[0], bwa[0], lg[0]}, 4'b0001);
    @(negedge clk);
    mem_write_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
